// File: rtl/stream_mux_arb_pkg.sv
// Shared types for the registered stream multiplexer: operating mode and index-width helper.
package stream_mux_arb_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    function automatic int sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_arb_if.sv
// Handshake bundle between N producers, the multiplexer and a single consumer.
interface stream_mux_arb_if
    import stream_mux_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 4
);
    localparam int SELW = sel_width(NCH);

    mode_e                  mode;
    logic [SELW-1:0]        sel;
    logic [NCH*WIDTH-1:0]   in_data;
    logic [NCH-1:0]         in_valid;
    logic [NCH-1:0]         in_ready;
    logic [WIDTH-1:0]       out_data;
    logic [SELW-1:0]        out_ch;
    logic                   out_valid;
    logic                   out_ready;
    logic                   sel_err;

    // Environment side: producers, consumer and mode/select control.
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid, sel_err
    );

    // Multiplexer side.
    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid, sel_err
    );

endinterface

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or after ptr, wrapping past NCH-1.
module stream_mux_arb_rr_arbiter
    import stream_mux_arb_pkg::*;
#(
    parameter int  NCH  = 4,
    localparam int SELW = sel_width(NCH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NCH-1:0]  req,
    input  logic            advance,
    output logic [NCH-1:0]  grant_oh,
    output logic [SELW-1:0] grant_idx,
    output logic            any
);

    logic [SELW-1:0] ptr_q, ptr_d;
    logic [NCH-1:0]  req_rot;
    logic [SELW:0]   offset;
    logic [SELW:0]   idx_wide;

    // Shifting {req, req} right by ptr lines channel ptr up with bit 0; the lowest set bit wins.
    always_comb begin
        req_rot  = NCH'({req, req} >> ptr_q);
        offset   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (req_rot[k]) offset = (SELW+1)'(k);
        end
        idx_wide = {1'b0, ptr_q} + offset;
        if (idx_wide >= (SELW+1)'(NCH)) idx_wide = idx_wide - (SELW+1)'(NCH);
    end

    assign any       = |req;
    assign grant_idx = idx_wide[SELW-1:0];
    assign grant_oh  = any ? (NCH'(1) << grant_idx) : '0;

    always_comb begin
        // NOTE: assign every combinational output a default first so no path leaves it unassigned (no latch).
        ptr_d = ptr_q;
        if (advance && any) begin
            ptr_d = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + SELW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/stream_mux_arb.sv
// Registered N-channel stream multiplexer: explicit-select or round-robin, one beat per cycle.
module stream_mux_arb
    import stream_mux_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NCH   = 4
) (
    input logic               clk,
    input logic               reset,
    stream_mux_arb_if.slave   bus
);

    localparam int SELW = sel_width(NCH);
    localparam int SELN = 1 << SELW;

    logic             mode_rr;
    logic             can_load;
    logic             sel_ok;
    logic             transfer;
    logic [SELN-1:0]  sel_in_range;
    logic [NCH-1:0]   sel_oh;
    logic [NCH-1:0]   rdy;
    logic [NCH-1:0]   grant_oh;
    logic [SELW-1:0]  grant_idx;
    logic             grant_any;
    logic [SELW-1:0]  chosen_idx;
    logic [WIDTH-1:0] sel_data;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic             sel_err_q,   sel_err_d;

    assign mode_rr  = (bus.mode == MODE_RR);
    assign can_load = !out_valid_q || bus.out_ready;

    // A select code is legal only when it names an existing channel (matters for non-power-of-2 NCH).
    always_comb begin
        for (int i = 0; i < SELN; i++) sel_in_range[i] = (i < NCH);
    end

    assign sel_ok = sel_in_range[bus.sel];
    assign sel_oh = NCH'(1) << bus.sel;

    stream_mux_arb_rr_arbiter #(.NCH(NCH)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (bus.in_valid),
        .advance   (mode_rr && transfer),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // In select mode ready is offered regardless of the selected channel's valid.
    always_comb begin
        rdy = '0;
        if (mode_rr)     rdy = grant_oh & {NCH{can_load}};
        else if (sel_ok) rdy = sel_oh & {NCH{can_load}};
    end

    assign bus.in_ready = rdy;
    assign transfer     = |(bus.in_valid & rdy);
    assign chosen_idx   = mode_rr ? grant_idx : bus.sel;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (chosen_idx == SELW'(k)) sel_data = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        sel_err_d   = sel_err_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_ch_d    = chosen_idx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (!mode_rr && !sel_ok && (|bus.in_valid)) sel_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            sel_err_q   <= sel_err_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Scoreboard bench: a 4-channel instance driven through both modes, plus a 3-channel instance for illegal select.
module tb_stream_mux_arb;
    import stream_mux_arb_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  ch;
    } beat_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stream_mux_arb_if #(.WIDTH(W), .NCH(4)) bus4 ();
    stream_mux_arb_if #(.WIDTH(W), .NCH(3)) bus3 ();

    stream_mux_arb #(.WIDTH(W), .NCH(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
    stream_mux_arb #(.WIDTH(W), .NCH(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] chan_data [4];
    int          ptr_m;
    logic        valid_m;
    beat_t       sb_q [$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input mode_e m, input logic [1:0] s, input logic [3:0] v, input logic ordy);
        bus4.mode      = m;
        bus4.sel       = s;
        bus4.in_valid  = v;
        bus4.out_ready = ordy;
        bus4.in_data   = {chan_data[3], chan_data[2], chan_data[1], chan_data[0]};
    endtask

    // One clock of the 4-channel instance: check at the falling edge, advance the model after the rising edge.
    task automatic cycle();
        logic [3:0] v;
        logic [3:0] exp_rdy;
        logic       can_m, have, xfer, was_rr;
        int         g;
        @(negedge clk);
        v       = bus4.in_valid;
        was_rr  = (bus4.mode == MODE_RR);
        can_m   = !valid_m || bus4.out_ready;
        exp_rdy = '0;
        have    = 1'b0;
        g       = 0;
        if (was_rr) begin
            for (int i = 0; i < 4; i++) begin
                int idx;
                idx = (ptr_m + i) % 4;
                if (!have && v[idx]) begin
                    g    = idx;
                    have = 1'b1;
                end
            end
            if (have && can_m) exp_rdy[g] = 1'b1;
        end else begin
            g = int'(bus4.sel);
            if (can_m) exp_rdy[g] = 1'b1;
        end
        check("in_ready", 64'(bus4.in_ready), 64'(exp_rdy));
        check("out_valid", 64'(bus4.out_valid), 64'(valid_m));
        check("sel_err4", 64'(bus4.sel_err), 64'(0));
        if (bus4.out_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_extra_beat", 64'(bus4.out_valid), 64'(0));
            end else begin
                check("out_data", 64'(bus4.out_data), 64'(sb_q[0].data));
                check("out_ch", 64'(bus4.out_ch), 64'(sb_q[0].ch));
                if (bus4.out_ready) void'(sb_q.pop_front());
            end
        end
        xfer = |(exp_rdy & v);
        if (xfer) sb_q.push_back('{data: chan_data[g], ch: 2'(g)});
        @(posedge clk);
        #1;
        if (xfer) begin
            valid_m = 1'b1;
            if (was_rr) ptr_m = (g + 1) % 4;
            chan_data[g] = chan_data[g] + 32'h10;
            bus4.in_data = {chan_data[3], chan_data[2], chan_data[1], chan_data[0]};
        end else if (bus4.out_ready) begin
            valid_m = 1'b0;
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        for (int k = 0; k < 4; k++) chan_data[k] = 32'hCAFE0000 + 32'(k);
        ptr_m   = 0;
        valid_m = 1'b0;
        drive(MODE_SEL, 2'd0, 4'b0000, 1'b1);
        bus3.mode      = MODE_SEL;
        bus3.sel       = 2'd0;
        bus3.in_valid  = 3'b000;
        bus3.out_ready = 1'b1;
        bus3.in_data   = {32'h33330002, 32'h33330001, 32'h33330000};

        // Reset values
        #12;
        check("rst_out_valid", 64'(bus4.out_valid), 64'(0));
        check("rst_out_data", 64'(bus4.out_data), 64'(0));
        check("rst_out_ch", 64'(bus4.out_ch), 64'(0));
        check("rst_sel_err", 64'(bus4.sel_err), 64'(0));
        check("rst_sel_err3", 64'(bus3.sel_err), 64'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Explicit select, sel=2
        drive(MODE_SEL, 2'd2, 4'b0100, 1'b1);
        cycle();
        drive(MODE_SEL, 2'd1, 4'b0001, 1'b1);
        cycle();
        drive(MODE_SEL, 2'd0, 4'b0001, 1'b1);
        cycle();
        drive(MODE_SEL, 2'd3, 4'b1000, 1'b1);
        cycle();

        // Round-robin over channels 1 and 3, then channel 3 alone
        drive(MODE_RR, 2'd0, 4'b1010, 1'b1);
        cycles(4);
        drive(MODE_RR, 2'd0, 4'b1000, 1'b1);
        cycles(2);
        drive(MODE_RR, 2'd0, 4'b0000, 1'b1);
        cycle();

        // Round-robin with all channels valid
        drive(MODE_RR, 2'd0, 4'b1111, 1'b1);
        cycles(8);

        // Mode switch keeps the pointer
        drive(MODE_SEL, 2'd3, 4'b1111, 1'b1);
        cycles(2);
        drive(MODE_RR, 2'd0, 4'b1111, 1'b1);
        cycles(3);

        // Backpressure for 3 cycles, then drain and load together
        drive(MODE_RR, 2'd0, 4'b1111, 1'b0);
        cycles(3);
        drive(MODE_RR, 2'd0, 4'b1111, 1'b1);
        cycles(2);
        drive(MODE_SEL, 2'd1, 4'b0010, 1'b0);
        cycles(2);
        drive(MODE_SEL, 2'd1, 4'b0010, 1'b1);
        cycle();
        drive(MODE_RR, 2'd0, 4'b0000, 1'b1);
        cycles(2);

        // Illegal select on the 3-channel instance
        check("sel_err3_pre", 64'(bus3.sel_err), 64'(0));
        bus3.sel      = 2'd3;
        bus3.in_valid = 3'b001;
        #1;
        check("in_ready3_bad_sel", 64'(bus3.in_ready), 64'(0));
        cycle();
        check("sel_err3_set", 64'(bus3.sel_err), 64'(1));
        check("out_valid3_none", 64'(bus3.out_valid), 64'(0));
        bus3.in_valid = 3'b000;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("sel_err3_sticky", 64'(bus3.sel_err), 64'(1));
        end

        // Reset in the middle of a stream
        drive(MODE_RR, 2'd0, 4'b1111, 1'b1);
        cycles(3);
        check("pre_rst_valid", 64'(bus4.out_valid), 64'(1));
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(bus4.out_valid), 64'(0));
        check("async_rst_sel_err3", 64'(bus3.sel_err), 64'(0));
        check("async_rst_ch", 64'(bus4.out_ch), 64'(0));
        valid_m = 1'b0;
        ptr_m   = 0;
        sb_q.delete();
        #2;
        reset = 1'b0;
        cycles(5);
        drive(MODE_RR, 2'd0, 4'b0000, 1'b1);
        cycles(2);
        check("sb_drained", 64'(sb_q.size()), 64'(0));
        check("sel_err3_after_rst", 64'(bus3.sel_err), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
